// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: LFSR-driven mole spawning, per-hole mole lifetimes,
// hit scoring with saturation, and a bounded game timer.
module mole_game_ctrl #(
  parameter int unsigned SPAWN_TICKS = 25_000_000,
  parameter int unsigned MOLE_TICKS  = 75_000_000,
  parameter int unsigned GAME_TICKS  = 32'd3_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit_valid,
  input  logic [3:0] hit_idx,
  output logic [8:0] map,
  output logic [3:0] score,
  output logic [2:0] cur_state
);

  localparam int unsigned SpawnW = $clog2(SPAWN_TICKS + 1);
  localparam int unsigned AgeW   = $clog2(MOLE_TICKS + 1);

  localparam logic [SpawnW-1:0] SpawnMax = SpawnW'(SPAWN_TICKS - 1);
  localparam logic [AgeW-1:0]   AgeMax   = AgeW'(MOLE_TICKS - 1);
  localparam logic [31:0]       GameMax  = GAME_TICKS - 32'd1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StGame = 3'd1,
    StFin  = 3'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        score_q, score_d;
  logic [8:0]        map_q, map_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [SpawnW-1:0] spawn_q, spawn_d;
  logic [31:0]       timer_q, timer_d;
  logic [AgeW-1:0]   age_q [9];
  logic [AgeW-1:0]   age_d [9];

  logic       lfsr_fb;
  logic [3:0] spawn_idx;
  logic       hit_ok;

  // Fibonacci taps 16,14,13,11 in right-shift form.
  assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign spawn_idx = (lfsr_q[3:0] < 4'd9) ? lfsr_q[3:0] : lfsr_q[3:0] - 4'd9;
  assign hit_ok    = hit_valid && (hit_idx < 4'd9) && map_q[hit_idx];

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    map_d   = map_q;
    lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
    spawn_d = spawn_q;
    timer_d = timer_q;
    age_d   = age_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StGame;
          score_d = '0;
          map_d   = '0;
          spawn_d = '0;
          timer_d = '0;
          for (int i = 0; i < 9; i++) age_d[i] = '0;
        end
      end

      StGame: begin
        for (int i = 0; i < 9; i++) begin
          if (map_q[i]) begin
            if (age_q[i] == AgeMax) map_d[i] = 1'b0;
            else                    age_d[i] = age_q[i] + AgeW'(1);
          end
        end

        if (spawn_q == SpawnMax) begin
          spawn_d = '0;
          if (!map_q[spawn_idx]) begin
            map_d[spawn_idx] = 1'b1;
            age_d[spawn_idx] = '0;
          end
        end else begin
          spawn_d = spawn_q + SpawnW'(1);
        end

        // Applied last so a hit overrides expiry on the same hole.
        if (hit_ok) begin
          map_d[hit_idx] = 1'b0;
          if (score_q != 4'd10) score_d = score_q + 4'd1;
        end

        if (score_q == 4'd10 || timer_q == GameMax) begin
          state_d = StFin;
          map_d   = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      StFin: begin
        if (start) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      score_q <= '0;
      map_q   <= '0;
      lfsr_q  <= 16'hACE1;
      spawn_q <= '0;
      timer_q <= '0;
      for (int i = 0; i < 9; i++) age_q[i] <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      map_q   <= map_d;
      lfsr_q  <= lfsr_d;
      spawn_q <= spawn_d;
      timer_q <= timer_d;
      age_q   <= age_d;
    end
  end

  assign map       = map_q;
  assign score     = score_q;
  assign cur_state = state_q;

endmodule
